// File: rtl/button_pkg.sv
// Shared definitions for the push-button conditioning logic.
// Holds the FSM state encoding, the production-sized timing defaults and a
// small timing set that keeps simulations short.
package button_pkg;

  // State encoding, also used by other blocks that decode button state.
  localparam logic [1:0] IDLE         = 2'd0;
  localparam logic [1:0] PRESS_WAIT   = 2'd1;
  localparam logic [1:0] HELD         = 2'd2;
  localparam logic [1:0] RELEASE_WAIT = 2'd3;

  typedef enum logic [1:0] {
    StIdle        = IDLE,
    StPressWait   = PRESS_WAIT,
    StHeld        = HELD,
    StReleaseWait = RELEASE_WAIT
  } state_e;

  // Production timing: 5 ms debounce and 0.5 s long press at 50 MHz.
  localparam int unsigned DefDebounceCycles = 250000;
  localparam int unsigned DefLongCycles     = 25000000;

  // Simulation-sized timing.
  localparam int unsigned SimDebounceCycles = 4;
  localparam int unsigned SimLongCycles     = 20;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for one asynchronous input bit, with asynchronous
// active-low clear. Used for the button pin and other slow board inputs.
//   clk_i  : destination clock
//   rst_ni : asynchronous active-low clear of both flops
//   d_i    : asynchronous input
//   q_o    : synchronized output, two clk_i edges of latency
module sync_2ff (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic q_o
);

  logic sync1_q;
  logic sync2_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= d_i;
      sync2_q <= sync1_q;
    end
  end

  assign q_o = sync2_q;

endmodule

// File: rtl/button_press_gen.sv
// Push-button conditioner: synchronizes a raw bouncy button, debounces both
// edges and emits single-cycle press / release / long-press pulses plus the
// debounced level. All outputs are registered.
//   clk            : system clock, rising edge
//   rst            : asynchronous active-low reset
//   button_in      : raw button pin, asynchronous, active-high
//   button_press   : one-cycle pulse per accepted press
//   button_release : one-cycle pulse per accepted release
//   long_press     : one-cycle pulse once per press held LONG_CYCLES
//   button_level   : debounced level (high in HELD and RELEASE_WAIT)
module button_press_gen
  import button_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DefDebounceCycles,
  parameter int unsigned LONG_CYCLES     = DefLongCycles
) (
  input  logic clk,
  input  logic rst,
  input  logic button_in,
  output logic button_press,
  output logic button_release,
  output logic long_press,
  output logic button_level
);

  localparam int unsigned DebW = $clog2(DEBOUNCE_CYCLES);
  localparam int unsigned HoldW = $clog2(LONG_CYCLES);
  localparam logic [DebW-1:0] DebMax = DebW'(DEBOUNCE_CYCLES - 1);
  localparam logic [HoldW-1:0] HoldMax = HoldW'(LONG_CYCLES - 1);

  logic sync2;

  sync_2ff u_sync (
    .clk_i  (clk),
    .rst_ni (rst),
    .d_i    (button_in),
    .q_o    (sync2)
  );

  state_e           state_q, state_d;
  logic [DebW-1:0]  deb_cnt_q, deb_cnt_d;
  logic [HoldW-1:0] hold_cnt_q, hold_cnt_d;
  logic             long_done_q, long_done_d;
  logic             press_q, press_d;
  logic             release_q, release_d;
  logic             long_q, long_d;
  logic             level_q, level_d;

  always_comb begin
    state_d     = state_q;
    deb_cnt_d   = deb_cnt_q;
    hold_cnt_d  = hold_cnt_q;
    long_done_d = long_done_q;
    press_d     = 1'b0;
    release_d   = 1'b0;
    long_d      = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (sync2) begin
          state_d   = StPressWait;
          deb_cnt_d = '0;
        end
      end
      StPressWait: begin
        if (!sync2) begin
          state_d = StIdle;
        end else if (deb_cnt_q == DebMax) begin
          state_d     = StHeld;
          press_d     = 1'b1;
          hold_cnt_d  = '0;
          long_done_d = 1'b0;
        end else begin
          deb_cnt_d = deb_cnt_q + DebW'(1);
        end
      end
      StHeld: begin
        if (!sync2) begin
          state_d   = StReleaseWait;
          deb_cnt_d = '0;
        end else begin
          if (hold_cnt_q != HoldMax) begin
            hold_cnt_d = hold_cnt_q + HoldW'(1);
          end
          // Fire on the edge the count reaches its end so long_press lands
          // LONG_CYCLES-1 edges after button_press.
          if ((hold_cnt_d == HoldMax) && !long_done_q) begin
            long_d      = 1'b1;
            long_done_d = 1'b1;
          end
        end
      end
      StReleaseWait: begin
        // hold_cnt is left untouched here; a bounce back to HELD resumes it.
        if (sync2) begin
          state_d = StHeld;
        end else if (deb_cnt_q == DebMax) begin
          state_d   = StIdle;
          release_d = 1'b1;
        end else begin
          deb_cnt_d = deb_cnt_q + DebW'(1);
        end
      end
      default: state_d = StIdle;
    endcase

    level_d = (state_d == StHeld) || (state_d == StReleaseWait);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= StIdle;
      deb_cnt_q   <= '0;
      hold_cnt_q  <= '0;
      long_done_q <= 1'b0;
      press_q     <= 1'b0;
      release_q   <= 1'b0;
      long_q      <= 1'b0;
      level_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      deb_cnt_q   <= deb_cnt_d;
      hold_cnt_q  <= hold_cnt_d;
      long_done_q <= long_done_d;
      press_q     <= press_d;
      release_q   <= release_d;
      long_q      <= long_d;
      level_q     <= level_d;
    end
  end

  assign button_press   = press_q;
  assign button_release = release_q;
  assign long_press     = long_q;
  assign button_level   = level_q;

endmodule

// File: tb/tb_button_press_gen.sv
// Scoreboard bench for button_press_gen with the simulation timing set.
// Stimulus pushes expected pulses {long, release, press} with the clock edge
// they must follow; a monitor pops and compares every pulse it sees.
module tb_button_press_gen;
  import button_pkg::*;

  localparam int Deb = SimDebounceCycles;
  localparam int Long = SimLongCycles;
  localparam int Lat = Deb + 2;

  localparam logic [2:0] EvPress = 3'b001;
  localparam logic [2:0] EvRelease = 3'b010;
  localparam logic [2:0] EvLong = 3'b100;

  typedef struct packed {
    logic [2:0] kind;
    int         at;
  } ev_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic button_in = 1'b0;
  logic button_press, button_release, long_press, button_level;

  ev_t exp_q[$];
  int  cyc = 0;
  int  n_cmp = 0;
  int  n_bad = 0;
  int  play_steps = 0;

  always #5 clk = ~clk;

  button_press_gen #(
    .DEBOUNCE_CYCLES (Deb),
    .LONG_CYCLES     (Long)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .button_in      (button_in),
    .button_press   (button_press),
    .button_release (button_release),
    .long_press     (long_press),
    .button_level   (button_level)
  );

  // Edge counter: after the n-th rising edge cyc == n.
  always @(posedge clk) cyc <= cyc + 1;

  // Stand-in for play_state_mcu: one state step per press pulse.
  always @(posedge clk) if (rst && button_press) play_steps <= play_steps + 1;

  // Monitor: compare every observed pulse against the head of the queue.
  logic [2:0] obs;
  ev_t        head;
  always @(negedge clk) begin
    if (exp_q.size() > 0 && exp_q[0].at < cyc) begin
      head = exp_q.pop_front();
      n_cmp++;
      n_bad++;
      $display("FAIL missed_pulse: got nothing, required kind=%b after edge %0d",
               head.kind, head.at);
    end
    obs = {long_press, button_release, button_press};
    if (obs != 3'b000) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_bad++;
        $display("FAIL unexpected_pulse: got kind=%b after edge %0d, required none", obs, cyc);
      end else begin
        head = exp_q.pop_front();
        if (head.kind !== obs || head.at != cyc) begin
          n_bad++;
          $display("FAIL pulse: got kind=%b after edge %0d, required kind=%b after edge %0d",
                   obs, cyc, head.kind, head.at);
        end
      end
    end
  end

  task automatic check(input string name, input int act, input int req);
    n_cmp++;
    if (act != req) begin
      n_bad++;
      $display("FAIL %s: got %0d, required %0d", name, act, req);
    end
  endtask

  task automatic expect_ev(input logic [2:0] kind, input int at);
    ev_t e;
    e.kind = kind;
    e.at = at;
    exp_q.push_back(e);
  endtask

  // Change button_in mid-cycle; k is the first edge that samples it.
  task automatic set_in(input logic v, output int k);
    @(negedge clk);
    button_in = v;
    k = cyc + 1;
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check_all_zero(input string tag);
    #1;
    check({tag, "_press"}, int'(button_press), 0);
    check({tag, "_release"}, int'(button_release), 0);
    check({tag, "_long"}, int'(long_press), 0);
    check({tag, "_level"}, int'(button_level), 0);
  endtask

  initial begin
    int k, r, snap;

    // 1. Reset, then idle.
    @(negedge clk);
    check_all_zero("in_reset");
    @(negedge clk);
    rst = 1'b1;
    wait_cyc(20);
    check_all_zero("idle");

    // 2. Clean press held 30 cycles.
    set_in(1'b1, k);
    expect_ev(EvPress, k + Lat);
    expect_ev(EvLong, k + Lat + Long - 1);
    wait_cyc(29);
    check("clean_level_held", int'(button_level), 1);
    set_in(1'b0, r);
    expect_ev(EvRelease, r + Lat);
    wait_cyc(19);
    check("clean_level_after", int'(button_level), 0);

    // 3. Glitches of 3 and 4 cycles are rejected.
    set_in(1'b1, k);
    wait_cyc(2);
    set_in(1'b0, k);
    wait_cyc(12);
    check("glitch3_level", int'(button_level), 0);
    set_in(1'b1, k);
    wait_cyc(3);
    check("glitch4_level_mid", int'(button_level), 0);
    set_in(1'b0, k);
    wait_cyc(12);
    check("glitch4_level", int'(button_level), 0);

    // 4. Release bounce: one press, one release, no long press.
    set_in(1'b1, k);
    expect_ev(EvPress, k + Lat);
    wait_cyc(9);
    for (int i = 0; i < 6; i++) set_in(i % 2 == 1, k);
    set_in(1'b0, r);
    check("bounce_level", int'(button_level), 1);
    expect_ev(EvRelease, r + Lat);
    wait_cyc(19);
    check("bounce_level_after", int'(button_level), 0);

    // 5. Reset in the 5th cycle of HELD with the button still down.
    set_in(1'b1, k);
    expect_ev(EvPress, k + Lat);
    wait_cyc(11);
    check("midhold_level", int'(button_level), 1);
    @(negedge clk);
    rst = 1'b0;
    check_all_zero("midhold_reset");
    @(negedge clk);
    rst = 1'b1;
    k = cyc + 1;
    expect_ev(EvPress, k + Lat);
    wait_cyc(9);
    set_in(1'b0, r);
    expect_ev(EvRelease, r + Lat);
    wait_cyc(19);

    // 6. Three separated presses drive the player one step each.
    snap = play_steps;
    for (int p = 0; p < 3; p++) begin
      set_in(1'b1, k);
      expect_ev(EvPress, k + Lat);
      wait_cyc(7);
      set_in(1'b0, r);
      expect_ev(EvRelease, r + Lat);
      wait_cyc(14);
    end
    check("play_steps", play_steps - snap, 3);

    wait_cyc(5);
    while (exp_q.size() > 0) begin
      ev_t e;
      e = exp_q.pop_front();
      n_cmp++;
      n_bad++;
      $display("FAIL missing_pulse: got nothing, required kind=%b after edge %0d", e.kind, e.at);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no end of test, required end before 200000");
    $fatal(1);
  end

endmodule
